// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register file: Num_Regs x Data_Width, independent write/read FSMs, READY 1 cycle and B/RVALID 2 cycles after valids.
// Backpressure: each channel holds its response until B/RREADY and accepts nothing new meanwhile.
module axi4_lite_slave #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int Num_Regs   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [Addr_Width-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [Data_Width-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [Addr_Width-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [Data_Width-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int Idx_W = $clog2(Num_Regs);
  localparam logic [Addr_Width-1:0] Addr_Limit = Addr_Width'(Num_Regs * 4);
  localparam logic [1:0] Resp_Okay   = 2'b00;
  localparam logic [1:0] Resp_Decerr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [Data_Width-1:0] regs [Num_Regs];

  logic             aw_ok, ar_ok, wr_commit;
  logic [Idx_W-1:0] aw_idx, ar_idx;

  logic                  aw_rdy_d, b_vld_d, ar_rdy_d, r_vld_d;
  logic [1:0]            bresp_d, rresp_d;
  logic [Data_Width-1:0] rdata_d;

  // Unaligned or beyond the register file both map to a decode error.
  assign aw_ok     = (AWADDR[1:0] == 2'b00) && (AWADDR < Addr_Limit);
  assign ar_ok     = (ARADDR[1:0] == 2'b00) && (ARADDR < Addr_Limit);
  assign aw_idx    = AWADDR[Idx_W+1:2];
  assign ar_idx    = ARADDR[Idx_W+1:2];
  assign wr_commit = (w_state == W_ACCEPT) && aw_ok;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < Num_Regs; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[aw_idx] <= WDATA;
    end
  end

  // Write channel: state and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= Resp_Okay;
    end else begin
      w_state <= w_next;
      AWREADY <= aw_rdy_d;
      WREADY  <= aw_rdy_d;
      BVALID  <= b_vld_d;
      BRESP   <= bresp_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (AWVALID && WVALID) w_next = W_ACCEPT;
      W_ACCEPT: w_next = W_RESP;
      W_RESP:   if (BREADY) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_rdy_d = (w_next == W_ACCEPT);
    b_vld_d  = (w_next == W_RESP);
    bresp_d  = BRESP;
    if (w_state == W_ACCEPT) bresp_d = aw_ok ? Resp_Okay : Resp_Decerr;
  end

  // Read channel: state and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= Resp_Okay;
    end else begin
      r_state <= r_next;
      ARREADY <= ar_rdy_d;
      RVALID  <= r_vld_d;
      RDATA   <= rdata_d;
      RRESP   <= rresp_d;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (ARVALID) r_next = R_ACCEPT;
      R_ACCEPT: r_next = R_DATA;
      R_DATA:   if (RREADY) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // Same-edge write to the read index is forwarded so the read sees the new value.
  always_comb begin
    ar_rdy_d = (r_next == R_ACCEPT);
    r_vld_d  = (r_next == R_DATA);
    rdata_d  = RDATA;
    rresp_d  = RRESP;
    if (r_state == R_ACCEPT) begin
      rresp_d = ar_ok ? Resp_Okay : Resp_Decerr;
      if (!ar_ok)                             rdata_d = '0;
      else if (wr_commit && aw_idx == ar_idx) rdata_d = WDATA;
      else                                    rdata_d = regs[ar_idx];
    end else if (r_next != R_DATA) begin
      rdata_d = '0;
      rresp_d = Resp_Okay;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Randomized bench for axi4_lite_slave: transaction-level register model plus per-cycle response checker.
module tb_axi4_lite_slave;

  logic        ACLK, ARESETN;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  axi4_lite_slave #(.Addr_Width(32), .Data_Width(32), .Num_Regs(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial begin
    ACLK = 0;
    forever #5 ACLK = ~ACLK;
  end

  int checks = 0;
  int failures = 0;

  logic [31:0] model [16];
  logic [1:0]  exp_bresp = 2'b00;
  logic [1:0]  exp_rresp = 2'b00;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd64);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1, 2: a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      3:       a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      default: a = 32'd64 + ($urandom_range(0, 255) << 2);
    endcase
    return a;
  endfunction

  // Write transaction: lead cycles with AWVALID only, then both valids; bdly cycles of BREADY=0.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lead, input int bdly,
                    output logic [1:0] resp);
    int n;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = d; AWVALID = 1; WVALID = (lead == 0); BREADY = 0;
    for (int i = 0; i < lead; i++) begin
      @(negedge ACLK);
      chk("awready_without_wvalid", {31'd0, AWREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    WVALID = 1;
    n = 0;
    do begin
      @(posedge ACLK); @(negedge ACLK); n++;
    end while (!(AWREADY && WREADY) && n < 20);
    chk("write_accept_latency", n, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0;
    if (addr_ok(a)) model[a[5:2]] = d;
    exp_bresp = addr_ok(a) ? 2'b00 : 2'b10;
    BREADY = (bdly == 0);
    @(negedge ACLK);
    chk("bvalid_latency", {31'd0, BVALID}, 32'd1);
    chk("awready_pulse", {30'd0, AWREADY, WREADY}, 32'd0);
    resp = BRESP;
    for (int i = 0; i < bdly; i++) begin
      @(posedge ACLK); @(negedge ACLK);
      chk("bvalid_hold", {31'd0, BVALID}, 32'd1);
    end
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    @(negedge ACLK);
    chk("bvalid_drop", {31'd0, BVALID}, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input int rdly, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1; RREADY = 0;
    n = 0;
    do begin
      @(posedge ACLK); @(negedge ACLK); n++;
    end while (!ARREADY && n < 20);
    chk("read_accept_latency", n, 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 0;
    RREADY = (rdly == 0);
    @(negedge ACLK);
    // Model already holds any write that committed on the capture edge.
    exp_rdata = addr_ok(a) ? model[a[5:2]] : 32'h0;
    exp_rresp = addr_ok(a) ? 2'b00 : 2'b10;
    chk("rvalid_latency", {31'd0, RVALID}, 32'd1);
    chk("arready_pulse", {31'd0, ARREADY}, 32'd0);
    data = RDATA; resp = RRESP;
    for (int i = 0; i < rdly; i++) begin
      @(posedge ACLK); @(negedge ACLK);
      chk("rvalid_hold", {31'd0, RVALID}, 32'd1);
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    @(negedge ACLK);
    chk("rvalid_drop", {31'd0, RVALID}, 32'd0);
  endtask

  // Per-cycle response checker
  initial begin
    forever begin
      @(negedge ACLK); #2;
      if (BVALID) chk("bresp", {30'd0, BRESP}, {30'd0, exp_bresp});
      if (RVALID) begin
        chk("rdata", RDATA, exp_rdata);
        chk("rresp", {30'd0, RRESP}, {30'd0, exp_rresp});
      end else begin
        chk("rdata_idle_zero", RDATA, 32'h0);
      end
    end
  end

  logic [1:0]  wresp, wresp2, rresp;
  logic [31:0] rdat;
  logic [31:0] ra, wa, wd;
  int          wl, wb, rb;

  initial begin
    ARESETN = 0; AWADDR = 0; WDATA = 0; AWVALID = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    model_clear();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    chk("reset_valid", {30'd0, BVALID, RVALID}, 32'd0);
    chk("reset_resp", {28'd0, BRESP, RRESP}, 32'd0);
    chk("reset_rdata", RDATA, 32'h0);
    @(posedge ACLK); #1;
    ARESETN = 1;

    // Basic write then read
    wr(32'h8, 32'hDEAD_BEEF, 0, 0, wresp);
    chk("basic_bresp", {30'd0, wresp}, 32'd0);
    rd(32'h8, 0, rdat, rresp);
    chk("basic_rdata", rdat, 32'hDEAD_BEEF);
    chk("basic_rresp", {30'd0, rresp}, 32'd0);

    // Decode errors
    wr(32'h40, 32'h5555_5555, 0, 1, wresp);
    chk("oor_bresp", {30'd0, wresp}, 32'd2);
    rd(32'h6, 1, rdat, rresp);
    chk("unaligned_rresp", {30'd0, rresp}, 32'd2);
    chk("unaligned_rdata", rdat, 32'h0);
    rd(32'h0, 0, rdat, rresp);
    chk("oor_no_alias", rdat, 32'h0);

    // Response held with BREADY low while a second write waits
    @(posedge ACLK); #1;
    AWADDR = 32'h10; WDATA = 32'h11; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(posedge ACLK); @(negedge ACLK);
    chk("hold_first_accept", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    model[4] = 32'h11; exp_bresp = 2'b00;
    AWADDR = 32'h14; WDATA = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("hold_bvalid", {31'd0, BVALID}, 32'd1);
      chk("hold_no_accept", {31'd0, AWREADY}, 32'd0);
      @(posedge ACLK); #1;
    end
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    @(negedge ACLK);
    chk("hold_release_bvalid", {31'd0, BVALID}, 32'd0);
    chk("hold_release_no_accept", {31'd0, AWREADY}, 32'd0);
    @(posedge ACLK); @(negedge ACLK);
    chk("hold_second_accept", {31'd0, AWREADY}, 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; model[5] = 32'h22; exp_bresp = 2'b00; BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
    rd(32'h14, 0, rdat, rresp);
    chk("hold_second_data", rdat, 32'h22);

    // Same-edge write and read of one register
    wr(32'h4, 32'hAAAA_AAAA, 0, 0, wresp);
    fork
      wr(32'h4, 32'h1234_5678, 0, 0, wresp2);
      rd(32'h4, 0, rdat, rresp);
    join
    chk("write_first_rdata", rdat, 32'h1234_5678);

    // AWVALID alone for 4 cycles
    wr(32'h18, 32'h77, 4, 0, wresp);
    chk("aw_lead_bresp", {30'd0, wresp}, 32'd0);

    // Randomized concurrent traffic
    for (int it = 0; it < 80; it++) begin
      wa = rand_addr(); ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      wd = $urandom(); wl = $urandom_range(0, 2); wb = $urandom_range(0, 3); rb = $urandom_range(0, 3);
      fork
        wr(wa, wd, wl, wb, wresp2);
        rd(ra, rb, rdat, rresp);
      join
    end

    // Reset during write accept
    @(posedge ACLK); #1;
    AWADDR = 32'hC; WDATA = 32'h5; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); @(negedge ACLK);
    chk("rst_in_accept", {31'd0, AWREADY}, 32'd1);
    #1 ARESETN = 0;
    model_clear();
    #1;
    chk("rst_abort_ready", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
    chk("rst_abort_valid", {30'd0, BVALID, RVALID}, 32'd0);
    chk("rst_abort_resp", {28'd0, BRESP, RRESP}, 32'd0);
    chk("rst_abort_rdata", RDATA, 32'h0);
    AWVALID = 0; WVALID = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1;
    rd(32'hC, 0, rdat, rresp);
    chk("rst_lost_write", rdat, 32'h0);
    rd(32'h8, 0, rdat, rresp);
    chk("rst_cleared_reg", rdat, 32'h0);

    repeat (2) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave.md
AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
REQ-001 SHALL have parameter Addr_Width, default 32, meaning AXI address width.
REQ-002 SHALL have parameter Data_Width, default 32, meaning AXI data and register width.
REQ-003 SHALL have parameter Num_Regs, default 16, meaning register file depth; power of two, at least 2.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- ACLK  in  1  sole clock, rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- AWADDR  in  Addr_Width  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  Data_Width  write data.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  master ready for response.
- ARADDR  in  Addr_Width  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  Data_Width  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  master ready for data.

Function
REQ-005 SHALL hold Num_Regs registers of Data_Width bits; register index = address bits [log2(Num_Regs)+1:2].
REQ-006 SHALL treat an address as valid only if bits [1:0] = 0 and address < Num_Regs*4; otherwise it is a decode error.
REQ-007 SHALL use an independent write FSM with states W_IDLE, W_ACCEPT, W_RESP; all write outputs registered.
REQ-008 Write, W_IDLE: AWREADY = WREADY = BVALID = 0; move to W_ACCEPT only on an edge where AWVALID and WVALID are both 1; if only one is valid, stay.
REQ-009 Write, W_ACCEPT: lasts exactly one cycle with AWREADY = WREADY = 1.
- On that cycle's closing edge: commit WDATA to the decoded register if the address is valid; register BRESP = 00 (valid) or 10 (decode error; no register changes); go to W_RESP.
REQ-010 Write, W_RESP: BVALID = 1, BRESP held stable; go to W_IDLE on the first edge with BREADY = 1; otherwise hold indefinitely.
REQ-011 SHALL use an independent read FSM with states R_IDLE, R_ACCEPT, R_DATA; all read outputs registered.
REQ-012 Read, R_IDLE: ARREADY = RVALID = 0; move to R_ACCEPT on an edge with ARVALID = 1.
REQ-013 Read, R_ACCEPT: lasts exactly one cycle with ARREADY = 1.
- On that cycle's closing edge: capture RDATA from the decoded register (or 0 on decode error) and RRESP = 00 or 10; go to R_DATA.
REQ-014 Read, R_DATA: RVALID = 1, RDATA and RRESP stable; go to R_IDLE on the first edge with RREADY = 1; otherwise hold.
REQ-015 Latency: valids sampled at edge 0 give READY high in cycle 1 and BVALID/RVALID high in cycle 2.
- Minimum back-to-back transaction period is 3 cycles per channel.
REQ-016 Read and write channels SHALL operate concurrently without interference.
- If a write commit and a read capture to the same valid index fall on the same edge, RDATA SHALL return the newly written data (write-first).
REQ-017 SHALL not accept a new transaction on a channel while that channel's response is pending.
REQ-018 RDATA SHALL be 0 whenever RVALID = 0.

Reset
REQ-019 While ARESETN = 0, regardless of clock:
- Both FSMs SHALL be in their IDLE states.
- AWREADY, WREADY, BVALID, ARREADY, RVALID SHALL be 0; BRESP, RRESP, RDATA SHALL be 0.
- All registers SHALL be cleared to 0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately.
- An un-committed write SHALL be lost.
- After release, the block SHALL wait in IDLE for fresh valids.

Verification
REQ-021 Write 0x0000_0008 <- 0xDEAD_BEEF with BREADY = 1, then read 0x8:
- AWREADY/WREADY pulse 1 cycle; BVALID 1 cycle later with BRESP = 00.
- RDATA = 0xDEAD_BEEF, RRESP = 00.
REQ-022 Write 0x0000_0040 (out of range, Num_Regs = 16) and read 0x0000_0006 (unaligned):
- Write gets BRESP = 10 and no register changes.
- Read gets RRESP = 10 with RDATA = 0.
REQ-023 Hold BREADY = 0 for 5 cycles after BVALID:
- BVALID and BRESP stay stable.
- A second AWVALID/WVALID is not accepted until 1 edge after BREADY = 1.
REQ-024 Same edge: write 0x4 <- 0x1234_5678 and read 0x4, with 0x4 previously 0xAAAA_AAAA: RDATA = 0x1234_5678.
REQ-025 AWVALID = 1 with WVALID = 0 for 4 cycles: AWREADY stays 0; after WVALID rises, AWREADY = WREADY = 1 in the following cycle.
REQ-026 Assert ARESETN = 0 during W_ACCEPT of write 0xC <- 0x5:
- All outputs go 0 immediately.
- After release, reading 0xC returns 0x0000_0000.
